ranked_leaderboard: RTL and testbench
=====================================

// Module: ranked_leaderboard
// PURPOSE
//  Parametrised, multi-bank sorted leaderboard of stopwatch times. Next generation of the fixed
//  3-entry slow/fast leaderboard. Accepts one captured time per valid/ready handshake and inserts
//  it in rank order into the selected bank with a sequential compare/shift engine. Reports the
//  rank achieved, which drives the rank LEDs and beep triggers. Exposes a registered read port
//  for the time display mux. Sits between the stopwatch core and the display/sound blocks.
// PARAMETERS
//  TIME_W    39     width of a stored time value
//  DEPTH     3      entries per bank (>=2)
//  RANK_W    2      rank/index width; 2**RANK_W must exceed DEPTH
//  BANKS     2      number of independent banks (one per stopwatch mode)
//  BANK_W    1      bank select width; 2**BANK_W >= BANKS
//  BANK_DESC 2'b10  per-bank order bit: 0 = smaller is better (ascending), 1 = larger is better
// PORTS
//  clock      in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-high; clears all state
//  in_valid   in   1       insert request
//  in_ready   out  1       engine idle; insert accepted on clock edge with in_valid&in_ready
//  in_time    in   TIME_W  time to insert
//  in_bank    in   BANK_W  target bank
//  clear      in   1       empty bank clr_bank (honoured in IDLE only)
//  clr_bank   in   BANK_W  bank to clear
//  rd_bank    in   BANK_W  read bank select
//  rd_idx     in   RANK_W  read index, 0 = best
//  rd_time    out  TIME_W  registered entry value (0 if entry empty or index out of range)
//  rd_hit     out  1       registered: entry at rd_idx holds a valid time
//  done       out  1       one-cycle pulse: insert finished
//  done_rank  out  RANK_W  rank achieved, 1..DEPTH; 0 = not placed; held until next done
// BEHAVIOUR
//  Reset:
//  - All entries invalid/0; rd_time=0, rd_hit=0, done=0, done_rank=0; state=IDLE.
//  - in_ready=0 while reset is high.
//  Handshake:
//  - in_ready = (state==IDLE) & ~clear; in_bank/in_time latched at accept.
//  - in_bank >= BANKS: request is accepted, completes with done_rank=0, no write.
//  FSM IDLE -> COMPARE -> SHIFT -> WRITE -> DONE -> IDLE:
//  - COMPARE: one entry per cycle from index 0; stops at first p where entry is invalid
//    or new is strictly better. Ties insert after existing equal values.
//  - COMPARE with no hit after DEPTH cycles goes to WRITE with the write suppressed, rank 0.
//  - SHIFT: entry[i] <= entry[i-1] (valid bit too) for i = DEPTH-1 down to p+1, one per cycle;
//    skipped when p = DEPTH-1. Old entry[DEPTH-1] is discarded.
//  - WRITE: entry[p] <= in_time, valid=1. done_rank <= p+1, or 0 on a miss.
//  - DONE: done=1 for one cycle; the next edge returns to IDLE.
//  Timing:
//  - Fixed latency: entering DONE occurs exactly DEPTH+1 edges after the accept edge,
//    hit or miss.
//  - in_ready is high again DEPTH+2 edges after the accept edge.
//  - Comparison is unsigned, full TIME_W.
//  Clear:
//  - Sampled only in IDLE; empties clr_bank on the next edge.
//  - clear and in_valid in the same cycle: clear wins, no accept.
//  - clear while busy is ignored.
//  Read port:
//  - 1-cycle latency; reflects array contents, which may be mid-shift during an insert.
//  - rd_idx >= DEPTH or rd_bank >= BANKS -> rd_time=0, rd_hit=0.
//  Reset mid-operation: engine aborts and the array empties immediately; no done is issued.
// TESTING
//  1 Reset, release -> in_ready=1, done=0, every bank/index reads rd_hit=0, rd_time=0.
//  2 Bank0 insert 500, 300, 400 -> done_rank 1, 1, 2; idx0..2 read 300, 400, 500;
//    each done exactly 4 edges after its accept.
//  3 Bank0 full, insert 600 -> done_rank=0, contents unchanged.
//    Then insert 100 -> rank 1; reads 100, 300, 400.
//  4 Tie: insert 300 into {100, 300, 400} -> done_rank=3; reads 100, 300, 300.
//  5 Bank1 (descending) insert 10 then 20 -> ranks 1, 1; bank1 reads 20, 10;
//    bank0 unchanged; rd_idx=3 -> rd_hit=0.
//  6 Assert reset during SHIFT -> no done; all rd_hit=0.
//    Separately, clear=1 with in_valid=1 in IDLE -> in_ready=0, bank emptied, no done.

Source files
------------

// File: rtl/ranked_leaderboard.sv
// ranked_leaderboard: multi-bank sorted leaderboard of stopwatch times.
// One insert at a time runs through a compare/shift/write engine whose
// latency does not depend on where the new time lands.
module ranked_leaderboard #(
  parameter int TIME_W = 39,
  parameter int DEPTH  = 3,
  parameter int RANK_W = 2,
  parameter int BANKS  = 2,
  parameter int BANK_W = 1,
  parameter logic [BANKS-1:0] BANK_DESC = 2'b10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TIME_W-1:0] in_time,
  input  logic [BANK_W-1:0] in_bank,
  input  logic              clear,
  input  logic [BANK_W-1:0] clr_bank,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [RANK_W-1:0] rd_idx,
  output logic [TIME_W-1:0] rd_time,
  output logic              rd_hit,
  output logic              done,
  output logic [RANK_W-1:0] done_rank
);

  typedef enum logic [2:0] {IDLE, COMPARE, SHIFT, WRITE, DONE} state_t;

  state_t              state, state_next;
  logic [TIME_W-1:0]   entry [BANKS][DEPTH];
  logic [DEPTH-1:0]    valid [BANKS];
  logic [TIME_W-1:0]   new_time;
  logic [BANK_W-1:0]   new_bank;
  logic [RANK_W-1:0]   idx;      // compare index, then shift destination index
  logic [RANK_W-1:0]   pos;      // insertion point found by COMPARE
  logic                placed;   // COMPARE found an insertion point

  logic                accept;
  logic                bank_ok;
  logic [BANK_W-1:0]   bsel;
  logic [TIME_W-1:0]   cur;
  logic                cur_valid;
  logic                better;
  logic                hit;
  logic                last;

  assign in_ready = (state == IDLE) && !clear && !reset;
  assign accept   = in_valid && in_ready;
  assign done     = (state == DONE);

  // Current comparison: strictly-better test keeps ties after existing equal values.
  always_comb begin
    bank_ok   = int'(new_bank) < BANKS;
    bsel      = bank_ok ? new_bank : '0;
    cur       = entry[bsel][idx];
    cur_valid = valid[bsel][idx];
    better    = BANK_DESC[bsel] ? (new_time > cur) : (new_time < cur);
    hit       = bank_ok && (!cur_valid || better);
    last      = int'(idx) == DEPTH - 1;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; cycle counts of COMPARE+SHIFT+WRITE always sum to DEPTH+1.
  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = COMPARE;
      COMPARE: begin
        if (hit)       state_next = last ? WRITE : SHIFT;
        else if (last) state_next = WRITE;
      end
      SHIFT:   if (idx == pos + RANK_W'(1)) state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Engine datapath and leaderboard array.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset because a mid-operation reset must empty the leaderboard at once.
      for (int b = 0; b < BANKS; b++) begin
        valid[b] <= '0;
        for (int d = 0; d < DEPTH; d++) entry[b][d] <= '0;
      end
      new_time  <= '0;
      new_bank  <= '0;
      idx       <= '0;
      pos       <= '0;
      placed    <= 1'b0;
      done_rank <= '0;
    end else begin
      // NOTE: non-blocking assignments so the shift reads pre-edge neighbours.
      unique case (state)
        IDLE: begin
          if (accept) begin
            new_time <= in_time;
            new_bank <= in_bank;
            idx      <= '0;
            placed   <= 1'b0;
          end else if (clear && int'(clr_bank) < BANKS) begin
            valid[clr_bank] <= '0;
            for (int d = 0; d < DEPTH; d++) entry[clr_bank][d] <= '0;
          end
        end
        COMPARE: begin
          if (hit) begin
            placed <= 1'b1;
            pos    <= idx;
            idx    <= RANK_W'(DEPTH - 1);
          end else begin
            idx <= idx + RANK_W'(1);
          end
        end
        SHIFT: begin
          entry[bsel][idx] <= entry[bsel][idx - RANK_W'(1)];
          valid[bsel][idx] <= valid[bsel][idx - RANK_W'(1)];
          idx              <= idx - RANK_W'(1);
        end
        WRITE: begin
          if (placed) begin
            entry[bsel][pos] <= new_time;
            valid[bsel][pos] <= 1'b1;
            done_rank        <= pos + RANK_W'(1);
          end else begin
            done_rank <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered read port; out-of-range or empty entries read as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_time <= '0;
      rd_hit  <= 1'b0;
    end else if (int'(rd_bank) < BANKS && int'(rd_idx) < DEPTH && valid[rd_bank][rd_idx]) begin
      rd_time <= entry[rd_bank][rd_idx];
      rd_hit  <= 1'b1;
    end else begin
      rd_time <= '0;
      rd_hit  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ranked_leaderboard.sv
// Directed bench for ranked_leaderboard: inserts, misses, ties, descending
// bank, read port range, reset mid-shift, and clear-vs-insert priority.
module tb_ranked_leaderboard;

  localparam int TIME_W = 39;
  localparam int RANK_W = 2;
  localparam int BANK_W = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] in_time;
  logic [BANK_W-1:0] in_bank;
  logic              clear;
  logic [BANK_W-1:0] clr_bank;
  logic [BANK_W-1:0] rd_bank;
  logic [RANK_W-1:0] rd_idx;
  logic [TIME_W-1:0] rd_time;
  logic              rd_hit;
  logic              done;
  logic [RANK_W-1:0] done_rank;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  ranked_leaderboard dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time), .in_bank(in_bank),
    .clear(clear), .clr_bank(clr_bank),
    .rd_bank(rd_bank), .rd_idx(rd_idx), .rd_time(rd_time), .rd_hit(rd_hit),
    .done(done), .done_rank(done_rank)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (done === 1'b1) done_seen++;

  // Handshake one insert; reports rank, edges from accept to done, and whether it timed out.
  task automatic do_insert(input logic [TIME_W-1:0] t, input logic [BANK_W-1:0] b,
                           output logic [RANK_W-1:0] rank, output int lat, output bit timeout);
    bit acc = 0;
    timeout = 0;
    lat = 0;
    rank = '0;
    in_time = t;
    in_bank = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) acc = 1;
      @(posedge clock);
    end
    #1 in_valid = 1'b0;
    if (!acc) begin
      timeout = 1;
      return;
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      @(posedge clock);
      #1 lat++;
    end
    if (done !== 1'b1) timeout = 1;
    rank = done_rank;
  endtask

  // Read one entry through the registered port.
  task automatic do_read(input logic [BANK_W-1:0] b, input logic [RANK_W-1:0] i,
                         output logic [TIME_W-1:0] t, output logic h);
    rd_bank = b;
    rd_idx  = i;
    @(posedge clock);
    #1;
    t = rd_time;
    h = rd_hit;
  endtask

  // Check three entries of a bank against expected values, all valid.
  task automatic expect_bank(input string name, input logic [BANK_W-1:0] b,
                             input logic [TIME_W-1:0] e0, input logic [TIME_W-1:0] e1,
                             input logic [TIME_W-1:0] e2);
    logic [TIME_W-1:0] exp_t [3];
    logic [TIME_W-1:0] t;
    logic h;
    exp_t[0] = e0; exp_t[1] = e1; exp_t[2] = e2;
    for (int i = 0; i < 3; i++) begin
      do_read(b, RANK_W'(i), t, h);
      checks++;
      if (h !== 1'b1 || t !== exp_t[i]) begin
        errors++;
        $display("FAIL %s bank%0d idx%0d: got hit=%b time=%0d, want hit=1 time=%0d",
                 name, b, i, h, t, exp_t[i]);
      end
    end
  endtask

  task automatic expect_all_empty(input string name);
    logic [TIME_W-1:0] t;
    logic h;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 4; i++) begin
        do_read(BANK_W'(b), RANK_W'(i), t, h);
        checks++;
        if (h !== 1'b0 || t !== '0) begin
          errors++;
          $display("FAIL %s bank%0d idx%0d: got hit=%b time=%0d, want hit=0 time=0",
                   name, b, i, h, t);
        end
      end
  endtask

  task automatic insert_check(input string name, input logic [TIME_W-1:0] t,
                              input logic [BANK_W-1:0] b, input logic [RANK_W-1:0] want_rank);
    logic [RANK_W-1:0] rank;
    int lat;
    bit to;
    do_insert(t, b, rank, lat, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s timeout: no accept/done within bound", name);
      return;
    end
    if (rank !== want_rank) begin
      errors++;
      $display("FAIL %s rank: got %0d, want %0d", name, rank, want_rank);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want 4", name, lat);
    end
    @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s return_idle: got ready=%b done=%b, want ready=1 done=0",
               name, in_ready, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_time = '0; in_bank = '0;
    clear = 1'b0; clr_bank = '0; rd_bank = '0; rd_idx = '0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b, want 0", in_ready);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0 || done_rank !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b done=%b rank=%0d, want 1 0 0",
               in_ready, done, done_rank);
    end
    @(posedge clock);
    #1;
    expect_all_empty("reset_read");
  endtask

  task automatic test_insert_order();
    insert_check("ins500", 39'd500, 1'b0, 2'd1);
    insert_check("ins300", 39'd300, 1'b0, 2'd1);
    insert_check("ins400", 39'd400, 1'b0, 2'd2);
    expect_bank("order", 1'b0, 39'd300, 39'd400, 39'd500);
  endtask

  task automatic test_full_miss();
    insert_check("miss600", 39'd600, 1'b0, 2'd0);
    expect_bank("miss_contents", 1'b0, 39'd300, 39'd400, 39'd500);
    insert_check("ins100", 39'd100, 1'b0, 2'd1);
    expect_bank("after100", 1'b0, 39'd100, 39'd300, 39'd400);
  endtask

  task automatic test_tie();
    insert_check("tie300", 39'd300, 1'b0, 2'd3);
    expect_bank("tie", 1'b0, 39'd100, 39'd300, 39'd300);
  endtask

  task automatic test_descending();
    logic [TIME_W-1:0] t;
    logic h;
    insert_check("desc10", 39'd10, 1'b1, 2'd1);
    insert_check("desc20", 39'd20, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      do_read(1'b1, RANK_W'(i), t, h);
      checks++;
      if (i == 0 && (h !== 1'b1 || t !== 39'd20) ||
          i == 1 && (h !== 1'b1 || t !== 39'd10) ||
          i == 2 && (h !== 1'b0 || t !== '0)) begin
        errors++;
        $display("FAIL desc_read idx%0d: got hit=%b time=%0d", i, h, t);
      end
    end
    expect_bank("bank0_kept", 1'b0, 39'd100, 39'd300, 39'd300);
    do_read(1'b0, 2'd3, t, h);
    checks++;
    if (h !== 1'b0 || t !== '0) begin
      errors++;
      $display("FAIL idx3_range: got hit=%b time=%0d, want hit=0 time=0", h, t);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen_before;
    bit acc = 0;
    in_time = 39'd50; in_bank = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) acc = 1;
      @(posedge clock);
    end
    #1 in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL midshift_accept: got no accept, want accept");
    end
    // 50 beats 100 at index 0, so the engine enters SHIFT on the next edge.
    @(posedge clock);
    #1 reset = 1'b1;
    seen_before = done_seen;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (done_seen !== seen_before) begin
      errors++;
      $display("FAIL midshift_done: got %0d done pulses, want 0", done_seen - seen_before);
    end
    expect_all_empty("midshift_read");
  endtask

  task automatic test_clear_priority();
    int seen_before;
    logic [TIME_W-1:0] t;
    logic h;
    insert_check("pre_clear", 39'd7, 1'b0, 2'd1);
    seen_before = done_seen;
    clear = 1'b1; clr_bank = 1'b0; in_valid = 1'b1; in_time = 39'd5; in_bank = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready: got %b, want 0", in_ready);
    end
    @(posedge clock);
    #1 clear = 1'b0; in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (done_seen !== seen_before) begin
      errors++;
      $display("FAIL clear_done: got %0d done pulses, want 0", done_seen - seen_before);
    end
    do_read(1'b0, 2'd0, t, h);
    checks++;
    if (h !== 1'b0 || t !== '0) begin
      errors++;
      $display("FAIL clear_emptied: got hit=%b time=%0d, want hit=0 time=0", h, t);
    end
  endtask

  initial begin
    test_reset();
    test_insert_order();
    test_full_miss();
    test_tie();
    test_descending();
    test_reset_mid_shift();
    test_clear_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
